// File: rtl/dcache_ctrl.sv
// dcache_ctrl
// Direct-mapped, write-through, no-write-allocate data cache controller.
// A request is taken from the address stage, looked up for one cycle, and
// then completed by a hit response, a 4-word line refill (loads), or a single
// memory write (stores). Hit and miss lookups are counted in saturating
// counters.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid / req_ready  request handshake (ready only while idle)
//   wr, cache_address_i,   request: store flag, byte address, store lanes
//   byte_en, wdata         and store data
//   resp_valid, rdata      one-cycle completion pulse with load data
//   mem_req ... mem_be     registered memory request, held until mem_ack
//   mem_ack, mem_rdata     memory completion and read data
//   hit_cnt, miss_cnt      saturating lookup counters
module dcache_ctrl #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             wr,
    input  logic [24:0]      cache_address_i,
    input  logic [3:0]       byte_en,
    input  logic [31:0]      wdata,
    output logic             resp_valid,
    output logic [31:0]      rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [24:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 25 - IDX_W - 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAG,
        ST_REFILL,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t             state_q, state_d;
    logic               wr_q, wr_d;
    logic [24:2]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               hit_q, hit_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [24:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES][4];

    logic               tag_we;
    logic               data_we;
    logic [3:0]         data_be;
    logic [1:0]         data_wr_off;
    logic [31:0]        data_wr_val;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         req_off;
    logic               lookup_hit;

    // The byte offset within a word never affects the lookup.
    logic               unused_byte_offset;
    assign unused_byte_offset = ^cache_address_i[1:0];

    assign req_idx    = addr_q[IDX_W+3:4];
    assign req_tag    = addr_q[24:IDX_W+4];
    assign req_off    = addr_q[3:2];
    assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // Next-state logic for the controller. A memory request is raised in the
    // first cycle of REFILL/WRITE while mem_req is low, held until the ack,
    // and dropped in the cycle after the ack, so each refill word is its own
    // transaction with a stable address.
    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        hit_d        = hit_q;
        valid_d      = valid_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        tag_we       = 1'b0;
        data_we      = 1'b0;
        data_be      = 4'hF;
        data_wr_off  = cnt_q;
        data_wr_val  = mem_rdata;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = wr;
                    addr_d  = cache_address_i[24:2];
                    be_d    = byte_en;
                    wdata_d = wdata;
                    state_d = ST_TAG;
                end
            end
            ST_TAG: begin
                hit_d = lookup_hit;
                if (lookup_hit) begin
                    if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
                end else begin
                    if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
                end
                if (wr_q) begin
                    state_d = ST_WRITE;
                end else if (lookup_hit) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = data_mem[req_idx][req_off];
                end else begin
                    state_d = ST_REFILL;
                    cnt_d   = 2'd0;
                end
            end
            ST_REFILL: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {addr_q[24:4], cnt_q, 2'b00};
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    data_we   = 1'b1;
                    cnt_d     = cnt_q + 2'd1;
                    // The line only becomes valid once the last word lands,
                    // so an aborted refill never leaves a half-filled hit.
                    if (cnt_q == 2'd3) begin
                        valid_d[req_idx] = 1'b1;
                        tag_we           = 1'b1;
                        state_d          = ST_RESP;
                        resp_valid_d     = 1'b1;
                        rdata_d          = (req_off == 2'd3) ? mem_rdata
                                                             : data_mem[req_idx][req_off];
                    end
                end
            end
            ST_WRITE: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {addr_q[24:2], 2'b00};
                    mem_wdata_d = wdata_q;
                    mem_be_d    = be_q;
                end else if (mem_ack) begin
                    // Write-through: the cached copy is patched only on a hit.
                    mem_req_d    = 1'b0;
                    data_we      = hit_q;
                    data_be      = be_q;
                    data_wr_off  = req_off;
                    data_wr_val  = wdata_q;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = 32'd0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            hit_q        <= 1'b0;
            valid_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            hit_q        <= hit_d;
            valid_q      <= valid_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Tag and data storage; contents are qualified by valid_q, so no reset.
    always_ff @(posedge clk) begin
        if (data_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be[b]) data_mem[req_idx][data_wr_off][8*b +: 8] <= data_wr_val[8*b +: 8];
            end
        end
        if (tag_we) tag_mem[req_idx] <= req_tag;
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl
// Directed testbench for dcache_ctrl. A behavioural memory acks every request
// two cycles after it appears and keeps stores; a monitor logs every completed
// memory transaction. The counters are built 4 bits wide so that saturation
// is reachable in a short run.
module tb_dcache_ctrl;

    localparam int IDX_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             wr;
    logic [24:0]      cache_address_i;
    logic [3:0]       byte_en;
    logic [31:0]      wdata;
    logic             resp_valid;
    logic [31:0]      rdata;
    logic             mem_req;
    logic             mem_we;
    logic [24:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;
    logic [31:0]      mem_rdata;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    typedef struct {
        logic        we;
        logic [24:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_txn_t;

    mem_txn_t      txq[$];
    logic [31:0]   mem_store[int];
    int            checks = 0;
    int            errors = 0;

    dcache_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .wr              (wr),
        .cache_address_i (cache_address_i),
        .byte_en         (byte_en),
        .wdata           (wdata),
        .resp_valid      (resp_valid),
        .rdata           (rdata),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
    );

    always #5 clk = ~clk;

    // Unwritten memory words hold 0x9C + word address (0x10 -> 0xA0).
    function automatic logic [31:0] readWord(input logic [24:0] a);
        if (mem_store.exists(int'(a))) return mem_store[int'(a)];
        return 32'(a[24:2]) + 32'h9C;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its response pulse.
    task automatic applyStimulus(input logic w, input logic [24:0] a, input logic [3:0] be,
                                 input logic [31:0] wd, output logic [31:0] rd, output int lat);
        int waited;
        bit done;
        waited = 0;
        done   = 1'b0;
        @(negedge clk);
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_req", 32'(req_ready), 32'd1);
        req_valid       = 1'b1;
        wr              = w;
        cache_address_i = a;
        byte_en         = be;
        wdata           = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (resp_valid) done = 1'b1;
        end
        checkOutput("resp_seen", 32'(done), 32'd1);
        rd = rdata;
        @(negedge clk);
        checkOutput("resp_one_cycle", 32'(resp_valid), 32'd0);
        checkOutput("ready_after_resp", 32'(req_ready), 32'd1);
    endtask

    // Memory responder: ack two cycles after the request appears.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !mem_ack) begin
                @(posedge clk);
                #1;
                mem_ack   = 1'b1;
                mem_rdata = mem_we ? 32'd0 : readWord(mem_addr);
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
            end
        end
    end

    // Transaction monitor; also applies completed writes to the memory model.
    logic [31:0] merged_word;
    mem_txn_t    logged_txn;
    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ack) begin
            logged_txn.we    = mem_we;
            logged_txn.addr  = mem_addr;
            logged_txn.wdata = mem_wdata;
            logged_txn.be    = mem_be;
            txq.push_back(logged_txn);
            if (mem_we) begin
                merged_word = readWord(mem_addr);
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) merged_word[8*b +: 8] = mem_wdata[8*b +: 8];
                end
                mem_store[int'(mem_addr)] = merged_word;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          base;
        int          waited;

        rst_n           = 1'b0;
        req_valid       = 1'b0;
        wr              = 1'b0;
        cache_address_i = '0;
        byte_en         = '0;
        wdata           = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        checkOutput("rst_miss_cnt", 32'(miss_cnt), 32'd0);

        // Cold load miss refills the whole line in word order.
        base = txq.size();
        applyStimulus(1'b0, 25'h10, 4'h0, 32'd0, rd, lat);
        $display("[TB] load 0x10 latency %0d", lat);
        checkOutput("miss_rdata", rd, 32'h0000_00A0);
        checkOutput("miss_cnt_1", 32'(miss_cnt), 32'd1);
        checkOutput("refill_txns", 32'(txq.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < txq.size()) begin
                checkOutput("refill_addr", 32'(txq[base+i].addr), 32'h10 + 32'(4*i));
                checkOutput("refill_we", 32'(txq[base+i].we), 32'd0);
            end
        end

        // Hit on the refilled line: two-cycle latency and no memory traffic.
        base = txq.size();
        applyStimulus(1'b0, 25'h18, 4'h0, 32'd0, rd, lat);
        checkOutput("hit_latency", 32'(lat), 32'd2);
        checkOutput("hit_rdata", rd, 32'h0000_00A2);
        checkOutput("hit_cnt_1", 32'(hit_cnt), 32'd1);
        checkOutput("hit_no_mem", 32'(txq.size() - base), 32'd0);

        // Store hits: one write each, cached word merged by byte lane.
        base = txq.size();
        applyStimulus(1'b1, 25'h14, 4'b0011, 32'h1234_5678, rd, lat);
        checkOutput("store_rdata", rd, 32'd0);
        checkOutput("store_txns", 32'(txq.size() - base), 32'd1);
        if (txq.size() > base) begin
            checkOutput("store_addr", 32'(txq[base].addr), 32'h14);
            checkOutput("store_we", 32'(txq[base].we), 32'd1);
            checkOutput("store_be", 32'(txq[base].be), 32'h3);
            checkOutput("store_wdata", txq[base].wdata, 32'h1234_5678);
        end
        applyStimulus(1'b1, 25'h18, 4'b1100, 32'hDEAD_BEEF, rd, lat);
        applyStimulus(1'b0, 25'h14, 4'h0, 32'd0, rd, lat);
        checkOutput("merge_low", rd, 32'h0000_5678);
        applyStimulus(1'b0, 25'h18, 4'h0, 32'd0, rd, lat);
        checkOutput("merge_high", rd, 32'hDEAD_00A2);
        checkOutput("hit_cnt_5", 32'(hit_cnt), 32'd5);

        // Store miss: write only, no allocate; the following load refills.
        base = txq.size();
        applyStimulus(1'b1, 25'h400, 4'b1111, 32'hCAFE_F00D, rd, lat);
        checkOutput("store_miss_txns", 32'(txq.size() - base), 32'd1);
        checkOutput("miss_cnt_2", 32'(miss_cnt), 32'd2);
        base = txq.size();
        applyStimulus(1'b0, 25'h400, 4'h0, 32'd0, rd, lat);
        checkOutput("noalloc_refill", 32'(txq.size() - base), 32'd4);
        checkOutput("noalloc_rdata", rd, 32'hCAFE_F00D);
        checkOutput("miss_cnt_3", 32'(miss_cnt), 32'd3);

        // Empty byte mask still writes memory but leaves the cache alone.
        base = txq.size();
        applyStimulus(1'b1, 25'h404, 4'b0000, 32'hFFFF_FFFF, rd, lat);
        checkOutput("be0_txns", 32'(txq.size() - base), 32'd1);
        applyStimulus(1'b0, 25'h404, 4'h0, 32'd0, rd, lat);
        checkOutput("be0_rdata", rd, 32'h0000_019D);
        checkOutput("hit_cnt_7", 32'(hit_cnt), 32'd7);

        // Conflict on index 1 evicts, then the original line misses again.
        applyStimulus(1'b0, 25'h110, 4'h0, 32'd0, rd, lat);
        checkOutput("conflict_rdata", rd, 32'h0000_00E0);
        applyStimulus(1'b0, 25'h10, 4'h0, 32'd0, rd, lat);
        checkOutput("evicted_rdata", rd, 32'h0000_00A0);
        checkOutput("miss_cnt_5", 32'(miss_cnt), 32'd5);
        applyStimulus(1'b0, 25'h14, 4'h0, 32'd0, rd, lat);
        checkOutput("wt_refill_rdata", rd, 32'h0000_5678);
        checkOutput("hit_cnt_8", 32'(hit_cnt), 32'd8);

        // Reset while the third refill word is outstanding.
        base = txq.size();
        @(negedge clk);
        req_valid       = 1'b1;
        wr              = 1'b0;
        cache_address_i = 25'h110;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        waited = 0;
        while (txq.size() < base + 2 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        while (!mem_req && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("pre_reset_mem_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_mem_req_drop", 32'(mem_req), 32'd0);
        checkOutput("async_miss_cnt", 32'(miss_cnt), 32'd0);
        checkOutput("async_req_ready", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("aborted_txns", 32'(txq.size() - base), 32'd2);

        applyStimulus(1'b0, 25'h10, 4'h0, 32'd0, rd, lat);
        checkOutput("post_reset_rdata", rd, 32'h0000_00A0);
        checkOutput("post_reset_miss", 32'(miss_cnt), 32'd1);
        applyStimulus(1'b0, 25'h400, 4'h0, 32'd0, rd, lat);
        checkOutput("post_reset_miss_400", 32'(miss_cnt), 32'd2);
        checkOutput("post_reset_rdata_400", rd, 32'hCAFE_F00D);
        applyStimulus(1'b0, 25'h10, 4'h0, 32'd0, rd, lat);
        checkOutput("post_reset_hit", 32'(hit_cnt), 32'd1);

        // Miss counter saturation with quick store misses.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, 25'(32'h800 + (i << 8)), 4'h0, 32'd0, rd, lat);
        end
        checkOutput("miss_cnt_max", 32'(miss_cnt), 32'hF);
        applyStimulus(1'b1, 25'h1F00, 4'h0, 32'd0, rd, lat);
        checkOutput("miss_cnt_sat", 32'(miss_cnt), 32'hF);
        checkOutput("hit_cnt_stable", 32'(hit_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller sitting directly downstream of the address-generation stage. Consumes cache_address_i, byte_en and wr, looks up an internal tag/data array, and on a read miss refills a 4-word line from memory over a req/ack interface. Returns read data to the core with a single-cycle response pulse and keeps saturating hit/miss counters.

Parameters:
IDX_W, 4, index bits; line count = 2**IDX_W (16 lines of 4 x 32-bit words)
CNT_W, 16, width of hit/miss performance counters

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present (address stage valid)
req_ready  out  1  controller can accept; high only in IDLE
wr  in  1  1 = store, 0 = load
cache_address_i  in  25  byte address: [1:0] ignored, [3:2] word offset, [IDX_W+3:4] index, [24:IDX_W+4] tag
byte_en  in  4  store byte lanes; ignored for loads
wdata  in  32  store data
resp_valid  out  1  one-cycle pulse, request complete
rdata  out  32  load data, valid with resp_valid; 0 for stores
mem_req  out  1  memory transaction request, held until mem_ack
mem_we  out  1  1 = memory write
mem_addr  out  25  word-aligned memory address ([1:0] = 00)
mem_wdata  out  32  memory write data
mem_be  out  4  memory write byte lanes
mem_ack  in  1  one-cycle completion; sampled only while mem_req = 1
mem_rdata  in  32  read data, valid with mem_ack
hit_cnt  out  CNT_W  lookup hits, saturating
miss_cnt  out  CNT_W  lookup misses, saturating

Behaviour:
- Reset (async, rst_n = 0): state IDLE; all line valid bits 0; req_ready = 1 after release; resp_valid, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be, hit_cnt, miss_cnt all 0. Tag/data arrays need no reset.
- Reset mid-operation: any refill/write aborted immediately; mem_req drops asynchronously; partially refilled line stays invalid.
- Accept: req_valid & req_ready at edge N latches wr, address, byte_en, wdata; state -> TAG.
- TAG (1 cycle): hit = valid[idx] & tag[idx] == addr tag.
  - Load hit: hit_cnt++; -> RESP with rdata = data[idx][off]. resp_valid high in cycle N+2.
  - Load miss: miss_cnt++; -> REFILL, word counter = 0.
  - Store (hit or miss): counts as hit/miss likewise; -> WRITE.
- REFILL: mem_req = 1, mem_we = 0, mem_addr = {tag, idx, cnt, 2'b00}; on mem_ack store mem_rdata into data[idx][cnt], cnt++. Words fetched in order 0,1,2,3 regardless of requested offset. After 4th ack: valid[idx] = 1, tag[idx] = req tag, -> RESP returning requested word.
- WRITE: mem_req = 1, mem_we = 1, mem_addr = {addr[24:2], 2'b00}, mem_wdata = wdata, mem_be = byte_en. On mem_ack -> RESP. If hit, cache word updated byte-wise per byte_en in the same cycle as the ack; miss leaves array unchanged (no allocate). byte_en = 0000 still issues the memory write; cache unchanged.
- RESP (1 cycle): resp_valid = 1, -> IDLE. req_ready = 0 in all states except IDLE; a new request can be accepted in the cycle after resp_valid.
- mem_req/mem_addr/mem_we/mem_wdata/mem_be are registered and stable from assertion until the ack cycle; mem_req deasserts the cycle after mem_ack. mem_ack while mem_req = 0 is ignored.
- Counters stop at 2**CNT_W - 1; no wrap.
- Read miss to a line whose index matches a valid line with a different tag evicts silently (write-through: nothing to write back).

Test Plan:
- Reset then load 0x0000_0010 -> miss_cnt = 1; four mem reads at 0x10,0x14,0x18,0x1C (ack each after 2 cycles, data 0xA0..0xA3); resp_valid with rdata = 0xA0; valid[1] set.
- Load 0x0000_0018 after previous -> no mem_req; resp_valid exactly 2 cycles after acceptance, rdata = 0xA2, hit_cnt = 1.
- Store 0x0000_0014, wdata 0x1234_5678, byte_en 0011 (line valid) -> mem write addr 0x14, be 0011; subsequent load 0x14 hits returning 0x0000_5678 merged over 0xA1 as 0x0000_5678 low half, upper half from 0xA1.
- Store miss to 0x0000_0400 -> one mem write, no refill; following load to 0x400 misses and refills.
- Conflict: load 0x0000_0010 then 0x0000_0110 (same index 1, different tag) -> second refills, then load 0x10 misses again.
- Assert rst_n = 0 after 2nd refill ack -> mem_req drops at once; after release load 0x10 misses (line invalid); preload miss_cnt to 0xFFFF and miss again -> stays 0xFFFF.
